// File: rtl/time_set_input.sv
// Button-driven mm:ss time entry: debounced SET/UP/DOWN, minute/second edit FSM, inactivity abort.
// Optional auto-repeat on held UP/DOWN is built when TIME_SET_AUTO_REPEAT_EN is defined.
module time_set_input #(
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int TIMEOUT_MS      = 10000
) (
  input  logic        CLOCK_1ms,
  input  logic        RESET,
  input  logic        BTN_SET,
  input  logic        BTN_UP,
  input  logic        BTN_DOWN,
  input  logic [11:0] load_time,
  output logic [11:0] Time,
  output logic        editing,
  output logic [1:0]  edit_field,
  output logic        done
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_MS + 1);
  localparam int unsigned TO_W = $clog2(TIMEOUT_MS + 1);

  if (REPEAT_RATE_MS < 1 || REPEAT_RATE_MS > REPEAT_DELAY_MS || DEBOUNCE_MS < 1 || TIMEOUT_MS < 2)
  begin : g_param_check
    $error("time_set_input: inconsistent timing parameters");
  end

  typedef enum logic [1:0] {IDLE, EDIT_MIN, EDIT_SEC} state_t;

  state_t          state, state_n;
  logic [2:0]      raw, sync1, sync2, level, level_d, press;
  logic [DB_W-1:0] db_cnt [3];
  logic [TO_W-1:0] to_cnt;
  logic [6:0]      min_r, saved_min, ld_min;
  logic [5:0]      sec_r, saved_sec, ld_sec;
  logic [12:0]     ld_clamp;
  logic            ev_set, ev_up, ev_down, act, timed_out, commit_q;
  logic            editing_c;
  logic [1:0]      field_c;
  logic [11:0]     time_c;

  // bit 0 = SET, bit 1 = UP, bit 2 = DOWN
  assign raw = {BTN_DOWN, BTN_UP, BTN_SET};

  always_ff @(posedge CLOCK_1ms or posedge RESET) begin
    if (RESET) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_MS - 1)) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign press  = level & ~level_d;
  assign ev_set = press[0];

`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam int unsigned RP_W = $clog2(REPEAT_DELAY_MS + 1);

  logic [RP_W-1:0] rp_cnt [2];
  logic [1:0]      rep;

  // Counter value equals cycles held since the press pulse; after the first repeat it
  // reloads so the next hit on REPEAT_DELAY_MS lands REPEAT_RATE_MS cycles later.
  always_comb begin
    rep = '0;
    for (int unsigned i = 0; i < 2; i++)
      rep[i] = level[i+1] && (state != IDLE) && (rp_cnt[i] == RP_W'(REPEAT_DELAY_MS));
  end

  always_ff @(posedge CLOCK_1ms or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < 2; i++) rp_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (!level[i+1] || state == IDLE || state_n != state)
          rp_cnt[i] <= '0;
        else if (rep[i])
          rp_cnt[i] <= RP_W'(REPEAT_DELAY_MS - REPEAT_RATE_MS + 1);
        else
          rp_cnt[i] <= rp_cnt[i] + RP_W'(1);
      end
    end
  end

  assign ev_up   = press[1] | rep[0];
  assign ev_down = press[2] | rep[1];
`else
  assign ev_up   = press[1];
  assign ev_down = press[2];
`endif

  assign act       = ev_set | ev_up | ev_down;
  assign timed_out = (state != IDLE) && !act && (to_cnt == TO_W'(TIMEOUT_MS - 1));

  assign ld_clamp = ({1'b0, load_time} > 13'd5999) ? 13'd5999 : {1'b0, load_time};
  assign ld_min   = 7'(ld_clamp / 13'd60);
  assign ld_sec   = 6'(ld_clamp % 13'd60);

  always_ff @(posedge CLOCK_1ms or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (ev_set) state_n = EDIT_MIN;
      EDIT_MIN: if (ev_set) state_n = EDIT_SEC; else if (timed_out) state_n = IDLE;
      EDIT_SEC: if (ev_set || timed_out) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    editing_c = (state == EDIT_MIN) || (state == EDIT_SEC);
    case (state)
      EDIT_MIN: field_c = 2'b01;
      EDIT_SEC: field_c = 2'b10;
      default:  field_c = 2'b00;
    endcase
    time_c = 12'(min_r) * 12'd60 + 12'(sec_r);
  end

  // SET outranks UP/DOWN; UP with DOWN cancels but still counts as activity.
  always_ff @(posedge CLOCK_1ms or posedge RESET) begin
    if (RESET) begin
      min_r     <= '0;
      sec_r     <= '0;
      saved_min <= '0;
      saved_sec <= '0;
      to_cnt    <= '0;
      commit_q  <= 1'b0;
    end else begin
      commit_q <= (state == EDIT_SEC) && ev_set;
      if (state_n == IDLE || state_n != state || act) to_cnt <= '0;
      else                                             to_cnt <= to_cnt + TO_W'(1);
      if (state == IDLE) begin
        if (ev_set) begin
          min_r     <= ld_min;
          sec_r     <= ld_sec;
          saved_min <= ld_min;
          saved_sec <= ld_sec;
        end
      end else if (!ev_set) begin
        if (timed_out) begin
          min_r <= saved_min;
          sec_r <= saved_sec;
        end else if (state == EDIT_MIN && (ev_up ^ ev_down)) begin
          if (ev_up) min_r <= (min_r == 7'd99) ? 7'd0 : min_r + 7'd1;
          else       min_r <= (min_r == 7'd0) ? 7'd99 : min_r - 7'd1;
        end else if (state == EDIT_SEC && (ev_up ^ ev_down)) begin
          if (ev_up) sec_r <= (sec_r == 6'd59) ? 6'd0 : sec_r + 6'd1;
          else       sec_r <= (sec_r == 6'd0) ? 6'd59 : sec_r - 6'd1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_1ms or posedge RESET) begin
    if (RESET) begin
      Time       <= '0;
      editing    <= 1'b0;
      edit_field <= 2'b00;
      done       <= 1'b0;
    end else begin
      Time       <= time_c;
      editing    <= editing_c;
      edit_field <= field_c;
      done       <= commit_q;
    end
  end

endmodule

// File: tb/tb_time_set_input.sv
// Directed bench for time_set_input: edit flow, bounce rejection, wraps, timeout, reset, collisions, repeat.
module tb_time_set_input;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        b_set = 1'b0, b_up = 1'b0, b_down = 1'b0;
  logic [11:0] load_time = '0;
  logic [11:0] Time;
  logic        editing, done;
  logic [1:0]  edit_field;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  time_set_input #(
    .DEBOUNCE_MS(20), .REPEAT_DELAY_MS(500), .REPEAT_RATE_MS(100), .TIMEOUT_MS(10000)
  ) dut (
    .CLOCK_1ms(clk), .RESET(rst), .BTN_SET(b_set), .BTN_UP(b_up), .BTN_DOWN(b_down),
    .load_time(load_time), .Time(Time), .editing(editing), .edit_field(edit_field), .done(done)
  );

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic s, input logic u, input logic d, input int hold);
    @(negedge clk);
    b_set = s; b_up = u; b_down = d;
    repeat (hold) @(negedge clk);
    b_set = 1'b0; b_up = 1'b0; b_down = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_time", 32'(Time), 0);
    check("rst_editing", 32'(editing), 0);
    check("rst_field", 32'(edit_field), 0);
    check("rst_done", 32'(done), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 12:34 -> +3 min -> 35 sec down wraps 34 to 59 -> 15:59
    load_time = 12'd754;
    pulse(1, 0, 0, 30);
    check("basic_editing", 32'(editing), 1);
    check("basic_field_min", 32'(edit_field), 1);
    check("basic_load", 32'(Time), 754);
    repeat (3) pulse(0, 1, 0, 30);
    check("basic_up3", 32'(Time), 934);
    pulse(1, 0, 0, 30);
    check("basic_field_sec", 32'(edit_field), 2);
    repeat (35) pulse(0, 0, 1, 30);
    check("basic_down35", 32'(Time), 959);
    check("basic_no_early_done", 32'(done_cnt), 0);
    pulse(1, 0, 0, 30);
    check("basic_field_none", 32'(edit_field), 0);
    check("basic_commit_editing", 32'(editing), 0);
    check("basic_commit_time", 32'(Time), 959);
    check("basic_done_once", 32'(done_cnt), 1);

    // bounce: 3-cycle toggles for 15 cycles, then held high
    load_time = 12'd0;
    pulse(1, 0, 0, 30);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      b_up = (k % 2 == 0);
      repeat (3) @(negedge clk);
    end
    b_up = 1'b1;
    repeat (25) @(negedge clk);
    b_up = 1'b0;
    repeat (40) @(negedge clk);
    check("bounce_single_inc", 32'(Time), 60);
    pulse(1, 0, 0, 30);
    pulse(1, 0, 0, 30);
    check("bounce_done", 32'(done_cnt), 2);

    // wraps; Time carries the low 12 bits of min*60+sec
    load_time = 12'd0;
    pulse(1, 0, 0, 30);
    pulse(0, 0, 1, 30);
    check("wrap_min_0_to_99", 32'(Time), (99 * 60) % 4096);
    pulse(0, 1, 0, 30);
    check("wrap_min_99_to_0", 32'(Time), 0);
    pulse(1, 0, 0, 30);
    pulse(0, 0, 1, 30);
    check("wrap_sec_0_to_59", 32'(Time), 59);
    pulse(0, 1, 0, 30);
    check("wrap_sec_59_to_0", 32'(Time), 0);
    pulse(1, 0, 0, 30);
    check("wrap_done", 32'(done_cnt), 3);

    // inactivity abort restores 10:00
    load_time = 12'd600;
    pulse(1, 0, 0, 30);
    pulse(0, 1, 0, 30);
    check("to_edited", 32'(Time), 660);
    repeat (9900) @(negedge clk);
    check("to_not_early", 32'(editing), 1);
    repeat (200) @(negedge clk);
    check("to_editing", 32'(editing), 0);
    check("to_restored", 32'(Time), 600);
    check("to_field", 32'(edit_field), 0);
    check("to_no_done", 32'(done_cnt), 3);

    // reset mid-edit
    pulse(1, 0, 0, 30);
    pulse(0, 1, 0, 30);
    check("rst_mid_pre", 32'(Time), 660);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_time", 32'(Time), 0);
    check("rst_mid_editing", 32'(editing), 0);
    check("rst_mid_field", 32'(edit_field), 0);
    check("rst_mid_done", 32'(done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_mid_no_done", 32'(done_cnt), 3);
    check("rst_mid_idle", 32'(editing), 0);

    // simultaneous events at 02:05
    load_time = 12'd125;
    pulse(1, 0, 0, 30);
    pulse(1, 1, 0, 30);
    check("sim_set_wins_field", 32'(edit_field), 2);
    check("sim_set_wins_time", 32'(Time), 125);
    pulse(0, 1, 1, 30);
    check("sim_updown_time", 32'(Time), 125);
    check("sim_updown_editing", 32'(editing), 1);
    pulse(1, 0, 0, 30);
    check("sim_done", 32'(done_cnt), 4);

    // held UP for 950 ms in EDIT_SEC from 00:00
    load_time = 12'd0;
    pulse(1, 0, 0, 30);
    pulse(1, 0, 0, 30);
    pulse(0, 1, 0, 950);
`ifdef TIME_SET_AUTO_REPEAT_EN
    check("hold_up", 32'(Time), 6);
`else
    check("hold_up", 32'(Time), 1);
`endif
    pulse(1, 0, 0, 30);
    check("hold_done", 32'(done_cnt), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
